// File: rtl/execute_stage.sv
// EX stage: ALU, destination select, iterative mul/div with HI/LO,
// stall generation and the EX/MEM pipeline register.
module execute_stage #(
  parameter int MD_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  wb_ID,
  input  logic [1:0]  m_ID,
  input  logic [3:0]  alu_op,
  input  logic [2:0]  md_op,
  input  logic        alu_src,
  input  logic        reg_dst,
  input  logic [31:0] read_data_1,
  input  logic [31:0] read_data_2,
  input  logic [31:0] imm_ext,
  input  logic [4:0]  shamt,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  output logic [1:0]  wb_MEM,
  output logic [1:0]  m,
  output logic [31:0] address_MEM,
  output logic [31:0] write_data_mem,
  output logic [4:0]  write_register_ex,
  output logic        stall,
  output logic        md_busy
);
  // 32 algorithm steps are spread over MD_CYCLES cycles, K steps per cycle
  localparam int STEPS = 32;
  localparam int K     = (STEPS + MD_CYCLES - 1) / MD_CYCLES;
  localparam int CW    = $clog2(MD_CYCLES + 1);

  typedef enum logic { S_IDLE, S_RUN } md_state_t;

  md_state_t   state_q, state_d;
  logic [CW-1:0] cnt;
  logic [31:0] op_b, alu_res, ex_res, hi, lo;
  logic        md_arith, md_any, start, last;
  logic [31:0] acc_hi, acc_lo, dv, dividend;
  logic        is_div, q_neg, r_neg, dz;
  logic [31:0] h, l, nxt_hi, nxt_lo;
  logic [32:0] sum, r;
  logic        a_neg, b_neg, sgn;
  logic [31:0] a_mag, b_mag;
  logic [63:0] prod;

  assign op_b     = alu_src ? imm_ext : read_data_2;
  assign md_arith = (md_op >= 3'd1) && (md_op <= 3'd4);
  assign md_any   = (md_op >= 3'd1) && (md_op <= 3'd6);
  assign md_busy  = (state_q == S_RUN);
  assign stall    = md_busy && md_any;
  assign start    = !md_busy && md_arith;
  assign last     = md_busy && (cnt == CW'(MD_CYCLES - 1));

  // ALU
  always_comb begin
    alu_res = 32'h0;
    case (alu_op)
      4'd0:  alu_res = read_data_1 & op_b;
      4'd1:  alu_res = read_data_1 | op_b;
      4'd2:  alu_res = read_data_1 + op_b;
      4'd3:  alu_res = read_data_1 - op_b;
      4'd4:  alu_res = {31'h0, $signed(read_data_1) < $signed(op_b)};
      4'd5:  alu_res = {31'h0, read_data_1 < op_b};
      4'd6:  alu_res = ~(read_data_1 | op_b);
      4'd7:  alu_res = read_data_1 ^ op_b;
      4'd8:  alu_res = op_b << shamt;
      4'd9:  alu_res = op_b >> shamt;
      4'd10: alu_res = $unsigned($signed(op_b) >>> shamt);
      4'd11: alu_res = {op_b[15:0], 16'h0};
      default: alu_res = 32'h0;
    endcase
  end

  assign ex_res = (md_op == 3'd5) ? hi : (md_op == 3'd6) ? lo : alu_res;

  // Operand magnitudes; signed ops run unsigned on magnitudes and fix sign at the end
  always_comb begin
    sgn   = (md_op == 3'd1) || (md_op == 3'd3);
    a_neg = sgn && read_data_1[31];
    b_neg = sgn && read_data_2[31];
    a_mag = a_neg ? -read_data_1 : read_data_1;
    b_mag = b_neg ? -read_data_2 : read_data_2;
  end

  // K shift-add / restoring-divide steps per cycle
  always_comb begin
    h   = acc_hi;
    l   = acc_lo;
    sum = 33'h0;
    r   = 33'h0;
    for (int j = 0; j < K; j++) begin
      if (int'(cnt) * K + j < STEPS) begin
        if (!is_div) begin
          sum = {1'b0, h} + (l[0] ? {1'b0, dv} : 33'h0);
          l   = {sum[0], l[31:1]};
          h   = sum[32:1];
        end else begin
          r = {h, l[31]};
          l = {l[30:0], 1'b0};
          if (r >= {1'b0, dv}) begin
            r    = r - {1'b0, dv};
            l[0] = 1'b1;
          end
          h = r[31:0];
        end
      end
    end
    nxt_hi = h;
    nxt_lo = l;
    prod   = q_neg ? -{h, l} : {h, l};
  end

  // Unit state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next state: run for MD_CYCLES cycles after an accepted start
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_RUN;
      S_RUN:  if (last)  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Mul/div datapath, iteration counter and HI/LO
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0; acc_hi <= '0; acc_lo <= '0; dv <= '0; dividend <= '0;
      is_div <= 1'b0; q_neg <= 1'b0; r_neg <= 1'b0; dz <= 1'b0;
      hi <= '0; lo <= '0;
    end else if (start) begin
      cnt      <= '0;
      acc_hi   <= '0;
      acc_lo   <= a_mag;
      dv       <= b_mag;
      dividend <= read_data_1;
      is_div   <= md_op[1] & md_op[0] | md_op[2];
      q_neg    <= a_neg ^ b_neg;
      r_neg    <= a_neg;
      dz       <= (read_data_2 == 32'h0);
    end else if (md_busy) begin
      acc_hi <= nxt_hi;
      acc_lo <= nxt_lo;
      cnt    <= cnt + 1'b1;
      if (last) begin
        if (!is_div) begin
          hi <= prod[63:32];
          lo <= prod[31:0];
        end else if (dz) begin
          hi <= dividend;
          lo <= 32'hFFFF_FFFF;
        end else begin
          hi <= r_neg ? -nxt_hi : nxt_hi;
          lo <= q_neg ? -nxt_lo : nxt_lo;
        end
      end
    end
  end

  // EX/MEM register: bubble on stall, MULT/DIV itself carries no control
  always_ff @(posedge clk or posedge rst) begin
    if (rst || 1'b0) begin
      wb_MEM <= '0; m <= '0; address_MEM <= '0;
      write_data_mem <= '0; write_register_ex <= '0;
    end else if (stall) begin
      wb_MEM <= '0; m <= '0; address_MEM <= '0;
      write_data_mem <= '0; write_register_ex <= '0;
    end else begin
      wb_MEM            <= start ? 2'b00 : wb_ID;
      m                 <= start ? 2'b00 : m_ID;
      address_MEM       <= ex_res;
      write_data_mem    <= read_data_2;
      write_register_ex <= reg_dst ? rd : rt;
    end
  end
endmodule
